// File: rtl/sm_run_ctrl_if.sv
// rtl/sm_run_ctrl_if.sv - host command handshake between the debug source and sm_run_ctrl
interface sm_run_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/step sequencer with PC breakpoint and cycle budget for sr_cpu
module sm_run_ctrl #(
  parameter int PC_W           = 32,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_BUDGET = 500
) (
  input  logic             clk,
  input  logic             rst,
  sm_run_ctrl_if.slave     cmd,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  output logic             cpu_en_o,
  output logic [1:0]       run_state_o,
  output logic [2:0]       halt_cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_SETB = 2'd3;

  localparam logic [2:0] CAUSE_RESET = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_STEP  = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_TMO   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] BUDGET_RST = CNT_W'(DEFAULT_BUDGET);

  state_e           state_q;
  logic [2:0]       halt_cause_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] budget_q;
  logic             bp_skip_q;
  logic             timeout_q;

  logic cmd_ready;
  logic cmd_acc;
  logic halt_acc;
  logic bp_hit;
  logic bud_hit;
  logic cpu_en;

  always_comb begin
    cmd_ready = (state_q != ST_STEP);
    cmd_acc   = cmd.cmd_valid & cmd_ready;
    halt_acc  = cmd_acc & (cmd.cmd_op == OP_HALT);
    bp_hit    = bp_en_i & (pc_i == bp_addr_i) & ~bp_skip_q;
    bud_hit   = (budget_q != '0) & (cycle_cnt_q == budget_q);
    cpu_en    = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = ~bp_hit & ~bud_hit & ~halt_acc;
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HALT;
      halt_cause_q <= CAUSE_RESET;
      cycle_cnt_q  <= '0;
      budget_q     <= BUDGET_RST;
      bp_skip_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (cpu_en) begin
        bp_skip_q <= 1'b0;
        if (cycle_cnt_q != CNT_MAX) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end
      // Counter clears below deliberately override the increment above.
      case (state_q)
        ST_HALT: begin
          if (cmd_acc) begin
            case (cmd.cmd_op)
              OP_RUN: begin
                state_q     <= ST_RUN;
                cycle_cnt_q <= '0;
                bp_skip_q   <= (halt_cause_q == CAUSE_BP);
              end
              OP_STEP: state_q <= ST_STEP;
              OP_HALT: halt_cause_q <= CAUSE_HOST;
              OP_SETB: begin
                budget_q    <= cmd.cmd_arg;
                cycle_cnt_q <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bp_hit) begin
            state_q      <= ST_HALT;
            halt_cause_q <= CAUSE_BP;
          end else if (bud_hit) begin
            state_q      <= ST_HALT;
            halt_cause_q <= CAUSE_TMO;
            timeout_q    <= 1'b1;
          end else if (halt_acc) begin
            state_q      <= ST_HALT;
            halt_cause_q <= CAUSE_HOST;
          end else if (cmd_acc && (cmd.cmd_op == OP_SETB)) begin
            budget_q    <= cmd.cmd_arg;
            cycle_cnt_q <= '0;
          end
        end
        ST_STEP: begin
          state_q      <= ST_HALT;
          halt_cause_q <= CAUSE_STEP;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign cmd.cmd_ready = cmd_ready;
  assign cpu_en_o      = cpu_en;
  assign run_state_o   = state_q;
  assign halt_cause_o  = halt_cause_q;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - self-checking bench for sm_run_ctrl
module tb_sm_run_ctrl;

  localparam int CNT_MAX = 65535;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        cpu_en;
  logic [1:0]  run_state;
  logic [2:0]  halt_cause;
  logic [15:0] cycle_cnt;
  logic        timeout;

  sm_run_ctrl_if #(.CNT_W(16)) cmd_if ();

  sm_run_ctrl #(.PC_W(32), .CNT_W(16), .DEFAULT_BUDGET(500)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if.slave),
    .pc_i         (pc),
    .bp_en_i      (bp_en),
    .bp_addr_i    (bp_addr),
    .cpu_en_o     (cpu_en),
    .run_state_o  (run_state),
    .halt_cause_o (halt_cause),
    .cycle_cnt_o  (cycle_cnt),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Behavioural model: mode 0=halted, 1=running, 2=stepping
  int m_state, m_cause, m_cnt, m_budget;
  bit m_skip, m_to;

  bit   last_en, last_rdy, last_to;
  int   last_st, last_ca, last_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_state = 0; m_cause = 0; m_cnt = 0; m_budget = 500; m_skip = 0; m_to = 0;
  endtask

  function automatic bit m_cpu_en(input bit v, input int op, input logic [31:0] p,
                                  input bit be, input logic [31:0] ba);
    bit bp, bud;
    if (m_state == 2) return 1'b1;
    if (m_state == 0) return 1'b0;
    bp  = be && (p == ba) && !m_skip;
    bud = (m_budget != 0) && (m_cnt == m_budget);
    return !bp && !bud && !(v && op == 1);
  endfunction

  task automatic m_step(input bit v, input int op, input int arg, input logic [31:0] p,
                        input bit be, input logic [31:0] ba);
    bit en, bp, bud, acc;
    en  = m_cpu_en(v, op, p, be, ba);
    bp  = be && (p == ba) && !m_skip;
    bud = (m_budget != 0) && (m_cnt == m_budget);
    acc = v && (m_state != 2);
    m_to = 0;
    if (en) begin
      m_skip = 0;
      m_cnt  = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    if (m_state == 0) begin
      if (acc && op == 0) begin m_skip = (m_cause == 3); m_cnt = 0; m_state = 1; end
      else if (acc && op == 2) m_state = 2;
      else if (acc && op == 1) m_cause = 1;
      else if (acc && op == 3) begin m_budget = arg; m_cnt = 0; end
    end else if (m_state == 1) begin
      if (bp)                  begin m_state = 0; m_cause = 3; end
      else if (bud)            begin m_state = 0; m_cause = 4; m_to = 1; end
      else if (acc && op == 1) begin m_state = 0; m_cause = 1; end
      else if (acc && op == 3) begin m_budget = arg; m_cnt = 0; end
    end else begin
      m_state = 0; m_cause = 2;
    end
  endtask

  // Every call starts and ends 1 time unit after a rising edge.
  task automatic cyc(input bit v, input int op, input int arg, input logic [31:0] p,
                     input bit be, input logic [31:0] ba);
    bit exp_en;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op[1:0];
    cmd_if.cmd_arg   = arg[15:0];
    pc = p; bp_en = be; bp_addr = ba;
    #3;
    exp_en = m_cpu_en(v, op, p, be, ba);
    check("cpu_en",     32'(cpu_en),          32'(exp_en));
    check("cmd_ready",  32'(cmd_if.cmd_ready), 32'(m_state != 2));
    check("run_state",  32'(run_state),       32'(m_state));
    check("halt_cause", 32'(halt_cause),      32'(m_cause));
    check("cycle_cnt",  32'(cycle_cnt),       32'(m_cnt));
    check("timeout",    32'(timeout),         32'(m_to));
    last_en = cpu_en; last_rdy = cmd_if.cmd_ready; last_to = timeout;
    last_st = int'(run_state); last_ca = int'(halt_cause); last_cnt = int'(cycle_cnt);
    m_step(v, op, arg, p, be, ba);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] p, input bit be, input logic [31:0] ba);
    cyc(1'b0, 0, 0, p, be, ba);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_arg = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit v; int op; int arg;
    bit en; bit rdy; int st; int ca; int cnt; bit to;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n_en, n_to, k;
    logic [31:0] p;
    n_pass = 0; n_total = 0;
    rst = 1'b1; pc = '0; bp_en = 1'b0; bp_addr = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_arg = '0;

    //          v  op arg en rdy st ca cnt to
    tbl[0]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 3, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 2, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 4, 3, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 4, 3, 0};
    tbl[9]  = '{1, 2, 0, 0, 1, 0, 4, 3, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 2, 4, 3, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 2, 4, 0};
    tbl[12] = '{1, 1, 0, 0, 1, 0, 2, 4, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 1, 4, 0};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 5; i++) idle(0, 0, 0);
    check("idle_en", 32'(last_en), 32'(0));
    check("idle_state", 32'(last_st), 32'(0));
    check("idle_cause", 32'(last_ca), 32'(0));
    check("idle_cnt", 32'(last_cnt), 32'(0));

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].op, tbl[i].arg, 0, 0, 0);
      check($sformatf("tbl%0d_en", i),    32'(last_en),  32'(tbl[i].en));
      check($sformatf("tbl%0d_rdy", i),   32'(last_rdy), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_state", i), 32'(last_st),  32'(tbl[i].st));
      check($sformatf("tbl%0d_cause", i), 32'(last_ca),  32'(tbl[i].ca));
      check($sformatf("tbl%0d_cnt", i),   32'(last_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_to", i),    32'(last_to),  32'(tbl[i].to));
    end

    // Budget of 10 cycles
    cyc(1, 3, 10, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_en = 0; n_to = 0;
    for (int i = 0; i < 30; i++) begin
      idle(0, 0, 0);
      n_en += int'(last_en);
      n_to += int'(last_to);
    end
    check("bud10_en_cycles", 32'(n_en), 32'(10));
    check("bud10_timeouts", 32'(n_to), 32'(1));
    check("bud10_cause", 32'(last_ca), 32'(4));
    check("bud10_cnt", 32'(last_cnt), 32'(10));

    // Breakpoint at 0x0C, unlimited budget, pc loops through 0x00..0x14
    cyc(1, 3, 0, 0, 1, 32'h0C);
    cyc(1, 0, 0, 0, 1, 32'h0C);
    k = 0; n_en = 0;
    for (int i = 0; i < 40; i++) begin
      p = 32'((k * 4) % 24);
      idle(p, 1, 32'h0C);
      if (!last_en) break;
      n_en++; k++;
    end
    check("bp1_en_cycles", 32'(n_en), 32'(3));
    check("bp1_halt_pc", p, 32'h0C);
    idle(p, 1, 32'h0C);
    check("bp1_cause", 32'(last_ca), 32'(3));
    cyc(1, 0, 0, p, 1, 32'h0C);
    n_en = 0;
    for (int i = 0; i < 40; i++) begin
      p = 32'((k * 4) % 24);
      idle(p, 1, 32'h0C);
      if (!last_en) break;
      n_en++; k++;
    end
    check("bp2_en_cycles", 32'(n_en), 32'(6));
    check("bp2_halt_pc", p, 32'h0C);
    idle(p, 1, 32'h0C);
    check("bp2_cause", 32'(last_ca), 32'(3));

    // Three single steps from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2, 0, 0, 0, 0);
      check("step_pre_en", 32'(last_en), 32'(0));
      idle(0, 0, 0);
      check("step_en", 32'(last_en), 32'(1));
      check("step_rdy", 32'(last_rdy), 32'(0));
    end
    idle(0, 0, 0);
    check("step_cause", 32'(last_ca), 32'(2));
    check("step_cnt", 32'(last_cnt), 32'(3));

    // HALT command collides with a breakpoint hit
    do_reset();
    cyc(1, 0, 0, 0, 1, 32'h10);
    for (int i = 0; i < 4; i++) begin
      idle(32'(i * 4), 1, 32'h10);
      check("hbp_run_en", 32'(last_en), 32'(1));
    end
    cyc(1, 1, 0, 32'h10, 1, 32'h10);
    check("hbp_en", 32'(last_en), 32'(0));
    idle(32'h10, 1, 32'h10);
    check("hbp_cause", 32'(last_ca), 32'(3));

    // Reset while running, then the default budget of 500
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) idle(0, 0, 0);
    do_reset();
    idle(0, 0, 0);
    check("rst_state", 32'(last_st), 32'(0));
    check("rst_cnt", 32'(last_cnt), 32'(0));
    check("rst_en", 32'(last_en), 32'(0));
    cyc(1, 0, 0, 0, 0, 0);
    n_en = 0; n_to = 0;
    for (int i = 0; i < 600; i++) begin
      idle(0, 0, 0);
      n_en += int'(last_en);
      n_to += int'(last_to);
      if (last_to) break;
    end
    check("default_budget_cycles", 32'(n_en), 32'(500));
    check("default_budget_timeout", 32'(n_to), 32'(1));

    // Unlimited budget: counter saturates, no timeout
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_to = 0;
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      idle(0, 0, 0);
      n_to += int'(last_to);
    end
    check("sat_cnt", 32'(last_cnt), 32'(CNT_MAX));
    check("sat_state", 32'(last_st), 32'(1));
    check("sat_timeouts", 32'(n_to), 32'(0));
    cyc(1, 1, 0, 0, 0, 0);
    idle(0, 0, 0);
    check("sat_host_cause", 32'(last_ca), 32'(1));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(3) == 0) p = 32'h0C;
        else p = {27'd0, 3'($urandom_range(7)), 2'b00};
        cyc(($urandom_range(2) == 0), int'($urandom_range(3)), int'($urandom_range(12)),
            p, ($urandom_range(3) != 0), 32'h0C);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
